// File: rtl/bit_field_normalizer.sv
// Bit-serial shifter/normalizer: turns a bit count into a shifted value or mask,
// or strips leading zeros/ones from an operand, one bit position per clock.
module bit_field_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_SHL_N  = 2'b00;
  localparam logic [1:0] OP_NORM_Z = 2'b01;
  localparam logic [1:0] OP_NORM_O = 2'b10;
  localparam logic [1:0] OP_MASK_N = 2'b11;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] step_reg, step_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             exit_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      work_reg   <= '0;
      target_reg <= '0;
      step_reg   <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      work_reg   <= work_next;
      target_reg <= target_next;
      step_reg   <= step_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  // Normalizing ops also stop after WIDTH steps so an all-zero/all-one operand terminates.
  always_comb begin
    exit_run = 1'b0;
    case (op_reg)
      OP_NORM_Z: exit_run = work_reg[WIDTH-1] || (step_reg == WIDTH_C);
      OP_NORM_O: exit_run = !work_reg[WIDTH-1] || (step_reg == WIDTH_C);
      default:   exit_run = (step_reg == target_reg);
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    work_next   = work_reg;
    target_next = target_reg;
    step_next   = step_reg;
    result_next = result_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next     = op;
          work_next   = (op == OP_MASK_N) ? '0 : A;
          target_next = (shamt > WIDTH_C) ? WIDTH_C : shamt;
          step_next   = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (exit_run) begin
          result_next = work_reg;
          count_next  = WIDTH'(step_reg);
          state_next  = DONE;
        end else begin
          step_next = step_reg + 1'b1;
          if (op_reg == OP_MASK_N)
            work_next = {1'b1, work_reg[WIDTH-1:1]};
          else
            work_next = {work_reg[WIDTH-2:0], 1'b0};
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign count  = count_reg;

endmodule

// File: tb/tb_bit_field_normalizer.sv
// Directed and randomized checks of bit_field_normalizer against hand-computed
// values and a leading-zero/one count model.
module tb_bit_field_normalizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [5:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] prev_res = '0;

  always #5 clk = ~clk;

  bit_field_normalizer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (a_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .count   (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clz(input logic [31:0] v);
    int c = 0;
    while (c < 32 && !v[31-c]) c++;
    return c;
  endfunction

  // One complete operation from an idle block; inputs are scrambled right after
  // acceptance to show they are not re-sampled.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [5:0] s, input logic [31:0] er, input int ec);
    int lat;
    int nbusy;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; shamt = s;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a_in = ~a; shamt = ~s;
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (lat == 1) check({tag, "/hold"}, result, prev_res);
    end while (!done && lat < 40);
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/lat"}, 32'(lat), 32'(ec + 2));
    check({tag, "/busy"}, 32'(nbusy), 32'(ec + 2));
    check({tag, "/result"}, result, er);
    check({tag, "/count"}, count, 32'(ec));
    @(negedge clk);
    check({tag, "/idle"}, 32'(busy), 32'd0);
    prev_res = er;
    $display("%s op=%0d A=%h shamt=%0d -> result=%h count=%0d latency=%0d",
             tag, o, a, s, result, count, lat);
  endtask

  initial begin
    int          k;
    int          ndone;
    logic [8:0]  bv;
    logic [8:0]  dv;
    logic [31:0] r;
    int          c;

    reset_n = 1'b0; start = 1'b0; op = '0; a_in = '0; shamt = '0;
    #12;
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/count", count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("normz_f0",   2'b01, 32'h00F0_0000, 6'd0,  32'hF000_0000, 8);
    run("normz_zero", 2'b01, 32'h0000_0000, 6'd0,  32'h0000_0000, 32);
    run("normz_msb",  2'b01, 32'h8000_0001, 6'd0,  32'h8000_0001, 0);
    run("normo_fff",  2'b10, 32'hFFF0_1234, 6'd0,  32'h0123_4000, 12);
    run("normo_ones", 2'b10, 32'hFFFF_FFFF, 6'd0,  32'h0000_0000, 32);
    run("normo_msb0", 2'b10, 32'h7FFF_FFFF, 6'd0,  32'h7FFF_FFFF, 0);
    run("shl_4",      2'b00, 32'h8000_0003, 6'd4,  32'h0000_0030, 4);
    run("shl_40",     2'b00, 32'hDEAD_BEEF, 6'd40, 32'h0000_0000, 32);
    run("shl_0",      2'b00, 32'h1234_5678, 6'd0,  32'h1234_5678, 0);
    run("shl_32",     2'b00, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 32);
    run("mask_5",     2'b11, 32'h1234_5678, 6'd5,  32'hF800_0000, 5);
    run("mask_0",     2'b11, 32'hFFFF_FFFF, 6'd0,  32'h0000_0000, 0);
    run("mask_63",    2'b11, 32'h0000_0000, 6'd63, 32'hFFFF_FFFF, 32);

    // Reset mid-operation: outputs clear before the next edge, no done follows.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'h0000_0001; shamt = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/result", result, 32'd0);
    check("abort/count", count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort/no_done", 32'(ndone), 32'd0);
    prev_res = '0;
    $display("abort op=1 A=00000001 -> reset mid-run, activity after release=%0d", ndone);

    // start pulsed during RUN with a different op/A must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'h0000_0001; shamt = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'h0000_FFFF; shamt = 6'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ignore/done", 32'(done), 32'd1);
    check("ignore/wait", 32'(k), 32'd29);
    check("ignore/result", result, 32'h8000_0000);
    check("ignore/count", count, 32'd31);
    repeat (3) @(negedge clk);
    check("ignore/noqueue", 32'(busy), 32'd0);
    prev_res = 32'h8000_0000;
    $display("ignore op=1 A=00000001 -> result=%h count=%0d", result, count);

    // start held high: accepted again one IDLE cycle after each DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 32'h0000_0005; shamt = 6'd0;
    @(posedge clk);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      bv[8-j] = busy;
      dv[8-j] = done;
    end
    start = 1'b0;
    check("b2b/busy", 32'(bv), 32'(9'b110_110_110));
    check("b2b/done", 32'(dv), 32'(9'b010_010_010));
    check("b2b/result", result, 32'h0000_0005);
    prev_res = 32'h0000_0005;
    $display("b2b op=0 A=00000005 shamt=0 -> busy=%b done=%b", bv, dv);

    for (int i = 0; i < 1000; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      c = clz(r);
      run("rand_z", 2'b01, r, 6'd0, r << c, c);
      r = ~($urandom >> $urandom_range(0, 31));
      c = clz(~r);
      run("rand_o", 2'b10, r, 6'd0, r << c, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
